// File: rtl/extmem_ctrl_if.sv
// Off-chip memory bus seen by the external wait-state controller.
// Master drives the request; the slave returns memdone.
interface extmem_ctrl_if #(
  parameter int ADDR_BITS = 13
);
  logic [ADDR_BITS-1:0] memadr;
  logic [3:0]           membyteen;
  logic                 memrwb;
  logic                 memen;
  logic                 memdone;

  modport master (
    output memadr,
    output membyteen,
    output memrwb,
    output memen,
    input  memdone
  );

  modport slave (
    input  memadr,
    input  membyteen,
    input  memrwb,
    input  memen,
    output memdone
  );
endinterface

// File: rtl/extmem_ctrl.sv
// Wait-state controller: off-chip memory bus to a single-port SRAM
// with one-cycle read latency and a four-phase memen/memdone handshake.
module extmem_ctrl #(
  parameter int ADDR_BITS  = 13,
  parameter int READ_WAIT  = 3,
  parameter int WRITE_WAIT = 2
) (
  input  logic                 ph1,
  input  logic                 reset,
  extmem_ctrl_if.slave         bus,
  inout  wire  [31:0]          memdata,
  output logic [ADDR_BITS-1:0] sram_adr,
  output logic [31:0]          sram_wdata,
  output logic [3:0]           sram_be,
  output logic                 sram_ce,
  output logic                 sram_we,
  input  logic [31:0]          sram_rdata
);

  localparam int MAX_WAIT =
    (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
  localparam int CW =
    (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  localparam logic [CW-1:0] RD_LOAD = CW'(READ_WAIT);
  localparam logic [CW-1:0] WR_LOAD = CW'(WRITE_WAIT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_ACCESS = 3'd2;
  localparam logic [2:0] S_RDATA  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]           r_state;
  logic [CW-1:0]        r_cnt;
  logic [31:0]          r_rbuf;
  logic [ADDR_BITS-1:0] r_adr;
  logic [3:0]           r_be;
  logic [31:0]          r_wdata;
  logic                 r_rwb;

  logic [CW-1:0]        w_load;
  logic                 w_drive;
  logic                 w_access;

  assign w_load   = bus.memrwb ? RD_LOAD : WR_LOAD;
  assign w_access = (r_state == S_ACCESS);

  // Read data only reaches the bus while the master still holds memen.
  assign w_drive = r_rwb && (r_state == S_DONE) && bus.memen;
  assign memdata = w_drive ? r_rbuf : 32'bz;

  assign bus.memdone = (r_state == S_DONE);

  assign sram_ce    = w_access;
  assign sram_we    = w_access & ~r_rwb;
  assign sram_adr   = r_adr;
  assign sram_be    = r_be;
  assign sram_wdata = r_wdata;

  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_rbuf  <= '0;
      r_adr   <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_rwb   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.memen) begin
            r_adr   <= bus.memadr;
            r_be    <= bus.membyteen;
            r_rwb   <= bus.memrwb;
            r_wdata <= memdata;
            r_cnt   <= w_load;
            r_state <= (w_load != '0) ? S_WAIT : S_ACCESS;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - CNT_ONE;
          if (r_cnt == CNT_ONE) begin
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_state <= r_rwb ? S_RDATA : S_DONE;
        end
        S_RDATA: begin
          r_rbuf  <= sram_rdata;
          r_state <= S_DONE;
        end
        S_DONE: begin
          if (!bus.memen) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_extmem_ctrl.sv
// Bench for extmem_ctrl: default and zero-wait instances, each
// with its own SRAM model and a transaction-level memory model.
module tb_extmem_ctrl;

  localparam int AB = 13;

  logic ph1 = 1'b0;
  logic reset;
  always #5 ph1 = ~ph1;

  logic          t_en  [2];
  logic          t_rwb [2];
  logic [AB-1:0] t_adr [2];
  logic [3:0]    t_be  [2];
  logic          t_drv [2];
  logic [31:0]   t_wd  [2];

  wire  [31:0]   t_md   [2];
  wire           t_done [2];
  wire           t_ce   [2];
  wire           t_we   [2];
  wire [AB-1:0]  t_sadr [2];
  wire [3:0]     t_sbe  [2];
  wire [31:0]    t_swd  [2];

  function automatic int rw(input int d);
    return (d == 0) ? 3 : 0;
  endfunction

  function automatic int ww(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gd
    localparam int RWT = (g == 0) ? 3 : 0;
    localparam int WWT = (g == 0) ? 2 : 0;

    extmem_ctrl_if #(.ADDR_BITS(AB)) bus ();
    wire  [31:0]   md;
    logic [AB-1:0] sadr;
    logic [31:0]   swd;
    logic [31:0]   srd;
    logic [3:0]    sbe;
    logic          sce;
    logic          swe;
    logic [31:0]   mem [0:(1<<AB)-1];

    assign bus.memen     = t_en[g];
    assign bus.memrwb    = t_rwb[g];
    assign bus.memadr    = t_adr[g];
    assign bus.membyteen = t_be[g];
    assign md            = t_drv[g] ? t_wd[g] : 32'bz;

    assign t_md[g]   = md;
    assign t_done[g] = bus.memdone;
    assign t_ce[g]   = sce;
    assign t_we[g]   = swe;
    assign t_sadr[g] = sadr;
    assign t_sbe[g]  = sbe;
    assign t_swd[g]  = swd;

    always @(posedge ph1) begin
      if (sce) begin
        if (swe) begin
          for (int k = 0; k < 4; k++)
            if (sbe[k]) mem[sadr][8*k +: 8] <= swd[8*k +: 8];
        end else begin
          srd <= mem[sadr];
        end
      end
    end

    extmem_ctrl #(
      .ADDR_BITS (AB),
      .READ_WAIT (RWT),
      .WRITE_WAIT(WWT)
    ) dut (
      .ph1       (ph1),
      .reset     (reset),
      .bus       (bus),
      .memdata   (md),
      .sram_adr  (sadr),
      .sram_wdata(swd),
      .sram_be   (sbe),
      .sram_ce   (sce),
      .sram_we   (swe),
      .sram_rdata(srd)
    );
  end

  int n_tests = 0;
  int n_fail  = 0;
  int bus_viol = 0;

  logic [31:0] refm [2][64];
  bit          wrtn [2][64];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old,
                                        input logic [31:0] nw,
                                        input logic [3:0]  be);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++)
      if (be[k]) r[8*k +: 8] = nw[8*k +: 8];
    return r;
  endfunction

  // Bus must float whenever memen is low and the master is silent.
  always @(posedge ph1) begin
    #2;
    for (int d = 0; d < 2; d++)
      if (!t_en[d] && !t_drv[d] && $countones(t_md[d]) != 0)
        bus_viol++;
  end

  task automatic txn(input int d, input bit rwb,
                     input logic [AB-1:0] adr,
                     input logic [3:0] be,
                     input logic [31:0] wd,
                     input int hold,
                     input logic [31:0] exp_rd);
    int wt, lat, n, ce_n, ce_cnt;
    string p;
    p = $sformatf("d%0d %s a%h", d, rwb ? "rd" : "wr", adr);
    wt = rwb ? rw(d) : ww(d);
    lat = rwb ? wt + 2 : wt + 1;
    ce_n = -1;
    ce_cnt = 0;
    @(negedge ph1);
    t_en[d] = 1'b1; t_rwb[d] = rwb; t_adr[d] = adr;
    t_be[d] = be; t_wd[d] = wd; t_drv[d] = !rwb;
    @(posedge ph1);
    #1;
    t_adr[d] = ~adr; t_be[d] = ~be; t_wd[d] = ~wd;
    for (n = 0; n < 40; n++) begin
      if (n > 0) begin
        @(posedge ph1);
        #1;
      end
      if (t_ce[d]) begin
        ce_cnt++;
        ce_n = n;
        chk({p, " sram_adr"}, 32'(t_sadr[d]), 32'(adr));
        chk({p, " sram_be"}, 32'(t_sbe[d]), 32'(be));
        chk({p, " sram_we"}, 32'(t_we[d]), 32'(!rwb));
        if (!rwb) chk({p, " sram_wdata"}, t_swd[d], wd);
      end
      if (t_done[d]) break;
    end
    chk({p, " latency"}, n, lat);
    chk({p, " ce_count"}, ce_cnt, 1);
    chk({p, " ce_edge"}, ce_n, wt);
    chk({p, " adr_hold"}, 32'(t_sadr[d]), 32'(adr));
    if (rwb) chk({p, " memdata"}, t_md[d], exp_rd);
    repeat (hold) begin
      @(posedge ph1);
      #1;
      chk({p, " done_hold"}, 32'(t_done[d]), 1);
      if (rwb) chk({p, " memdata_hold"}, t_md[d], exp_rd);
    end
    @(negedge ph1);
    t_en[d] = 1'b0;
    t_drv[d] = 1'b0;
    #1;
    if (rwb) chk({p, " release"}, $countones(t_md[d]), 0);
    @(posedge ph1);
    #1;
    chk({p, " done_fall"}, 32'(t_done[d]), 0);
    if (!rwb) begin
      refm[d][adr[5:0]] = merge(refm[d][adr[5:0]], wd, be);
      wrtn[d][adr[5:0]] = 1'b1;
    end
  endtask

  task automatic early_drop(input int d,
                            input logic [AB-1:0] adr,
                            input logic [31:0] wd);
    int dn, dfirst, ce_n;
    dn = 0; dfirst = -1; ce_n = -1;
    @(negedge ph1);
    t_en[d] = 1'b1; t_rwb[d] = 1'b0; t_adr[d] = adr;
    t_be[d] = 4'hf; t_wd[d] = wd; t_drv[d] = 1'b1;
    for (int n = 0; n < ww(d) + 4; n++) begin
      @(posedge ph1);
      #1;
      if (t_ce[d]) ce_n = n;
      if (t_done[d]) begin
        dn++;
        if (dfirst < 0) dfirst = n;
      end
      if (n == 0) begin
        @(negedge ph1);
        t_en[d] = 1'b0;
        t_drv[d] = 1'b0;
      end
    end
    chk($sformatf("d%0d drop ce_edge", d), ce_n, ww(d));
    chk($sformatf("d%0d drop done_cnt", d), dn, 1);
    chk($sformatf("d%0d drop done_edge", d), dfirst, ww(d) + 1);
    refm[d][adr[5:0]] = wd;
    wrtn[d][adr[5:0]] = 1'b1;
  endtask

  typedef struct {
    bit          rwb;
    logic [12:0] adr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b0, 13'h10, 4'hf, 32'hDEADBEEF, 32'h0};
    tbl[1] = '{1'b1, 13'h10, 4'hf, 32'h0, 32'hDEADBEEF};
    tbl[2] = '{1'b0, 13'h04, 4'hf, 32'hFFFFFFFF, 32'h0};
    tbl[3] = '{1'b0, 13'h04, 4'h5, 32'h11223344, 32'h0};
    tbl[4] = '{1'b1, 13'h04, 4'h3, 32'h0, 32'hFF22FF44};
    tbl[5] = '{1'b0, 13'h08, 4'hf, 32'h01020304, 32'h0};
    tbl[6] = '{1'b0, 13'h08, 4'h0, 32'hA5A5A5A5, 32'h0};
    tbl[7] = '{1'b1, 13'h08, 4'h0, 32'h0, 32'h01020304};

    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      t_en[d] = 1'b0; t_rwb[d] = 1'b0; t_adr[d] = '0;
      t_be[d] = '0; t_drv[d] = 1'b0; t_wd[d] = '0;
      for (int a = 0; a < 64; a++) begin
        refm[d][a] = '0;
        wrtn[d][a] = 1'b0;
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("d%0d rst memdone", d), 32'(t_done[d]), 0);
      chk($sformatf("d%0d rst sram_ce", d), 32'(t_ce[d]), 0);
      chk($sformatf("d%0d rst sram_we", d), 32'(t_we[d]), 0);
      chk($sformatf("d%0d rst sram_adr", d), 32'(t_sadr[d]), 0);
      chk($sformatf("d%0d rst sram_be", d), 32'(t_sbe[d]), 0);
      chk($sformatf("d%0d rst sram_wdata", d), t_swd[d], 0);
      chk($sformatf("d%0d rst release", d),
          $countones(t_md[d]), 0);
    end
    repeat (2) @(posedge ph1);
    @(negedge ph1);
    reset = 1'b0;

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 8; i++)
        txn(d, tbl[i].rwb, tbl[i].adr, tbl[i].be,
            tbl[i].wd, i % 3, tbl[i].exp);

    for (int d = 0; d < 2; d++) begin
      txn(d, 1'b1, 13'h10, 4'hf, 32'h0, 0, 32'hDEADBEEF);
      txn(d, 1'b1, 13'h04, 4'hf, 32'h0, 0, 32'hFF22FF44);
      early_drop(d, 13'h20, 32'hCAFEF00D);
      txn(d, 1'b1, 13'h20, 4'hf, 32'h0, 1, 32'hCAFEF00D);
    end

    // Reset while a read sits in WAIT.
    @(negedge ph1);
    t_en[0] = 1'b1; t_rwb[0] = 1'b1; t_adr[0] = 13'h10;
    t_be[0] = 4'hf; t_drv[0] = 1'b0;
    @(posedge ph1);
    @(posedge ph1);
    #2 reset = 1'b1;
    #1;
    chk("wait_rst memdone", 32'(t_done[0]), 0);
    chk("wait_rst sram_ce", 32'(t_ce[0]), 0);
    chk("wait_rst release", $countones(t_md[0]), 0);
    @(negedge ph1);
    @(posedge ph1);
    #2 reset = 1'b0;
    txn(0, 1'b1, 13'h10, 4'hf, 32'h0, 0, 32'hDEADBEEF);

    // Reset while read data is on the bus.
    @(negedge ph1);
    t_en[0] = 1'b1; t_rwb[0] = 1'b1; t_adr[0] = 13'h04;
    t_be[0] = 4'hf; t_drv[0] = 1'b0;
    for (int k = 0; k < 20 && !t_done[0]; k++) begin
      @(posedge ph1);
      #1;
    end
    chk("done_rst pre memdone", 32'(t_done[0]), 1);
    chk("done_rst pre memdata", t_md[0], 32'hFF22FF44);
    #2 reset = 1'b1;
    #1;
    chk("done_rst memdone", 32'(t_done[0]), 0);
    chk("done_rst release", $countones(t_md[0]), 0);
    @(negedge ph1);
    t_en[0] = 1'b0;
    #1 reset = 1'b0;

    for (int i = 0; i < 80; i++) begin
      int d, a, hold;
      bit rd;
      logic [3:0] be;
      logic [31:0] wd;
      d = i % 2;
      a = $urandom_range(0, 63);
      rd = $urandom_range(0, 1) == 1;
      be = 4'($urandom);
      wd = $urandom;
      hold = $urandom_range(0, 2);
      if (!wrtn[d][a]) begin
        rd = 1'b0;
        be = 4'hf;
      end
      txn(d, rd, AB'(a), be, wd, hold, refm[d][a]);
    end

    chk("bus_release_monitor", bus_viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
